branch_target_predictor: RTL and testbench

//   IF-stage branch predictor (direct-mapped BTB + 2-bit saturating counters) for the RV32I pipeline.
//   IF-side lookup: predicts taken/target for the fetch PC.
//   EX-side update: trained by the EX-stage branch decision result (actual taken + computed target).

---
 rtl/branch_target_predictor.sv | 112 +++++++++++
 tb/tb_branch_target_predictor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Lookup is combinational for the IF stage.
// Updates and branch/miss statistics are driven by the EX-stage branch resolution.
module branch_target_predictor #(
  parameter int unsigned ENTRY_BITS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_br,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  localparam int unsigned Entries = 2 ** ENTRY_BITS;
  localparam int unsigned TagW    = 30 - ENTRY_BITS;

  logic            r_valid  [Entries];
  logic [TagW-1:0] r_tag    [Entries];
  logic [31:0]     r_target [Entries];
  logic [1:0]      r_ctr    [Entries];
  logic [31:0]     r_br_count;
  logic [31:0]     r_miss_count;

  logic [ENTRY_BITS-1:0] w_if_idx;
  logic [TagW-1:0]       w_if_tag;
  logic                  w_if_hit;
  logic [ENTRY_BITS-1:0] w_ex_idx;
  logic [TagW-1:0]       w_ex_tag;
  logic                  w_ex_hit;
  logic                  w_resolve;
  logic                  w_mispredict;
  logic [31:0]           w_ex_pc_plus4;

  assign w_if_idx = i_pc_if[ENTRY_BITS+1:2];
  assign w_if_tag = i_pc_if[31:ENTRY_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign w_ex_idx      = i_ex_pc[ENTRY_BITS+1:2];
  assign w_ex_tag      = i_ex_pc[31:ENTRY_BITS+2];
  assign w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_resolve     = i_ex_valid && i_ex_is_branch;
  assign w_ex_pc_plus4 = i_ex_pc + 32'd4;

  // Lookup sees pre-update table contents; no bypass from a same-cycle update.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = i_pc_if + 32'd4;
    if (w_if_hit && r_ctr[w_if_idx][1]) begin
      o_pred_taken  = 1'b1;
      o_pred_target = r_target[w_if_idx];
    end
  end

  always_comb begin
    w_mispredict  = 1'b0;
    o_redirect_pc = w_ex_pc_plus4;
    if (w_resolve) begin
      w_mispredict = (i_ex_br != i_ex_pred_taken) ||
                     (i_ex_br && i_ex_pred_taken && (i_ex_pred_target != i_ex_target));
      if (i_ex_br) o_redirect_pc = i_ex_target;
    end else if (i_ex_valid) begin
      // A non-branch predicted taken sent fetch down a bogus path.
      w_mispredict = i_ex_pred_taken;
    end
  end

  assign o_mispredict = w_mispredict;
  assign o_br_count   = r_br_count;
  assign o_miss_count = r_miss_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_resolve) begin
        r_br_count <= r_br_count + 32'd1;
        if (w_ex_hit) begin
          if (i_ex_br) begin
            if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            r_target[w_ex_idx] <= i_ex_target;
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (i_ex_br) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= i_ex_target;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end
      if (w_mispredict) r_miss_count <= r_miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus randomized traffic
// checked against an index/tag/counter model built from plain arithmetic.
module tb_branch_target_predictor;

  localparam int NENT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_br, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, miss_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per index, tag kept as pc/256, counter as plain int 0..3.
  bit          m_valid  [NENT];
  int unsigned m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_ctr    [NENT];
  logic [31:0] m_br, m_miss;

  branch_target_predictor #(.ENTRY_BITS(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc_if(pc_if),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch), .i_ex_pc(ex_pc), .i_ex_br(ex_br),
    .i_ex_target(ex_target), .i_ex_pred_taken(ex_pred_taken),
    .i_ex_pred_target(ex_pred_target), .o_mispredict(mispredict),
    .o_redirect_pc(redirect_pc), .o_br_count(br_count), .o_miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == pc / 256);
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_ptaken(pc) ? m_target[midx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    if (!ex_valid) return 1'b0;
    if (!ex_is_branch) return ex_pred_taken;
    if (ex_br != ex_pred_taken) return 1'b1;
    return ex_br && (ex_pred_target != ex_target);
  endfunction

  function automatic logic [31:0] m_redirect();
    return (ex_valid && ex_is_branch && ex_br) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic model_update();
    int k;
    k = midx(ex_pc);
    if (m_misp()) m_miss = m_miss + 1;
    if (ex_valid && ex_is_branch) begin
      m_br = m_br + 1;
      if (m_hit(ex_pc)) begin
        if (ex_br) begin
          m_ctr[k]    = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
          m_target[k] = ex_target;
        end else begin
          m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
        end
      end else if (ex_br) begin
        m_valid[k]  = 1'b1;
        m_tag[k]    = ex_pc / 256;
        m_target[k] = ex_target;
        m_ctr[k]    = 2;
      end
    end
  endtask

  // Advance one clock: model sees the same inputs the DUT samples at the coming edge.
  task automatic cycle();
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_ex(input bit v, input bit b, input logic [31:0] pc, input bit br,
                          input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_br = br;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_if = 32'h100;
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    model_reset();
    #2;
    checks++; if (pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++;
      $display("FAIL reset_pred_target got=%h exp=00000104", pred_target); end
    checks++; if (br_count !== 32'h0 || miss_count !== 32'h0) begin errors++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_count, miss_count); end
    checks++; if (mispredict !== 1'b0) begin errors++;
      $display("FAIL reset_mispredict got=%0b exp=0", mispredict); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_resolve_and_allocate();
    pc_if = 32'h100;
    drive_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin errors++;
      $display("FAIL first_taken got=%0b/%h exp=1/00000080", mispredict, redirect_pc); end
    cycle();
    drive_ex(0, 1, 32'h100, 1, 32'h80, 1, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++;
      $display("FAIL alloc_predict got=%0b/%h exp=1/00000080", pred_taken, pred_target); end
    checks++; if (mispredict !== 1'b0 || redirect_pc !== 32'h104) begin errors++;
      $display("FAIL invalid_ex got=%0b/%h exp=0/00000104", mispredict, redirect_pc); end
    cycle();
    // Non-branch carrying a taken prediction.
    drive_ex(1, 0, 32'h300, 0, 32'h0, 1, 32'h80);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h304) begin errors++;
      $display("FAIL nonbranch got=%0b/%h exp=1/00000304", mispredict, redirect_pc); end
    cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (br_count !== 32'd1 || miss_count !== 32'd2) begin errors++;
      $display("FAIL counts_after_basic got=%0d/%0d exp=1/2", br_count, miss_count); end
  endtask

  task automatic test_counter_training();
    pc_if = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
      cycle();
    end
    drive_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin errors++;
      $display("FAIL nt_resolve got=%0b/%h exp=1/00000104", mispredict, redirect_pc); end
    cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++;
      $display("FAIL ctr_10_predict got=%0b/%h exp=1/00000080", pred_taken, pred_target); end
    drive_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL ctr_01_predict got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    checks++; if (br_count !== m_br || miss_count !== m_miss) begin errors++;
      $display("FAIL counts_training got=%0d/%0d exp=%0d/%0d", br_count, miss_count, m_br, m_miss); end
  endtask

  task automatic test_aliasing();
    drive_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    cycle();
    drive_ex(1, 1, 32'h200, 1, 32'h40, 0, 32'h204);
    cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    pc_if = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL alias_evicted got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    pc_if = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin errors++;
      $display("FAIL alias_new got=%0b/%h exp=1/00000040", pred_taken, pred_target); end
    cycle();
  endtask

  task automatic test_same_cycle();
    pc_if = 32'h200;
    // Drop the 0x200 entry to weakly not-taken first.
    drive_ex(1, 1, 32'h200, 0, 32'h40, 1, 32'h40);
    cycle();
    drive_ex(1, 1, 32'h200, 1, 32'h40, 0, 32'h204);
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin errors++;
      $display("FAIL same_cycle_old got=%0b/%h exp=0/00000204", pred_taken, pred_target); end
    cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin errors++;
      $display("FAIL same_cycle_next got=%0b/%h exp=1/00000040", pred_taken, pred_target); end
    cycle();
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2);
  endfunction

  task automatic test_random();
    logic [31:0] p;
    for (int n = 0; n < 300; n++) begin
      pc_if = rand_pc();
      p = rand_pc();
      if ($urandom_range(0, 3) != 0)
        drive_ex($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, p, $urandom_range(0, 1),
                 32'h2000 + ($urandom_range(0, 3) << 4), m_ptaken(p), m_ptarget(p));
      else
        drive_ex($urandom_range(0, 1), $urandom_range(0, 1), p, $urandom_range(0, 1),
                 32'h2000 + ($urandom_range(0, 3) << 4), $urandom_range(0, 1),
                 32'h2000 + ($urandom_range(0, 3) << 4));
      #1;
      checks++; if (pred_taken !== m_ptaken(pc_if) || pred_target !== m_ptarget(pc_if)) begin
        errors++;
        $display("FAIL rnd_predict pc=%h got=%0b/%h exp=%0b/%h", pc_if, pred_taken, pred_target,
                 m_ptaken(pc_if), m_ptarget(pc_if));
      end
      checks++; if (mispredict !== m_misp() || redirect_pc !== m_redirect()) begin errors++;
        $display("FAIL rnd_resolve got=%0b/%h exp=%0b/%h", mispredict, redirect_pc, m_misp(),
                 m_redirect());
      end
      checks++; if (br_count !== m_br || miss_count !== m_miss) begin errors++;
        $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", br_count, miss_count, m_br, m_miss);
      end
      cycle();
    end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1;
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_ex(1, 1, 32'h300, 1, 32'h500, 0, 32'h304); cycle();
    drive_ex(1, 1, 32'h300, 1, 32'h500, 1, 32'h500); cycle();
    drive_ex(1, 1, 32'h300, 1, 32'h500, 1, 32'h500); cycle();
    drive_ex(1, 1, 32'h300, 0, 32'h500, 1, 32'h500); cycle();
    drive_ex(1, 1, 32'h340, 0, 32'h600, 0, 32'h344); cycle();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    pc_if = 32'h300;
    #1;
    checks++; if (br_count !== 32'd5 || miss_count !== 32'd2) begin errors++;
      $display("FAIL pre_reset_counts got=%0d/%0d exp=5/2", br_count, miss_count); end
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin errors++;
      $display("FAIL pre_reset_predict got=%0b/%h exp=1/00000500", pred_taken, pred_target); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (br_count !== 32'd0 || miss_count !== 32'd0) begin errors++;
      $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", br_count, miss_count); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin errors++;
      $display("FAIL async_reset_predict got=%0b/%h exp=0/00000304", pred_taken, pred_target); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0 || br_count !== 32'd0) begin errors++;
      $display("FAIL post_reset got=%0b/%0d exp=0/0", pred_taken, br_count); end
  endtask

  initial begin
    test_reset();
    test_resolve_and_allocate();
    test_counter_training();
    test_aliasing();
    test_same_cycle();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
